// File: rtl/pld_shift_pkg.sv
// Shared encodings for the parallel-load shift register parameters.
package pld_shift_pkg;
  localparam int SHIFT_LEFT  = 0;
  localparam int SHIFT_RIGHT = 1;
  localparam int FILL_ZERO   = 0;
  localparam int FILL_ROTATE = 1;
endpackage

// File: rtl/pld_shift_reg.sv
// Parallel-load shift register: loads din or shifts one bit per edge; pout is the register itself.
// Latency: one edge for load, shift or reset; no handshake and no backpressure.
module pld_shift_reg
  import pld_shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SHIFT_DIR = SHIFT_LEFT,
  parameter int FILL_MODE = FILL_ZERO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pout
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shift_val;

  if (WIDTH < 2) begin : g_bad_width
    $error("pld_shift_reg: WIDTH must be at least 2");
  end
  if (SHIFT_DIR != SHIFT_LEFT && SHIFT_DIR != SHIFT_RIGHT) begin : g_bad_dir
    $error("pld_shift_reg: SHIFT_DIR must be 0 or 1");
  end
  if (FILL_MODE != FILL_ZERO && FILL_MODE != FILL_ROTATE) begin : g_bad_fill
    $error("pld_shift_reg: FILL_MODE must be 0 or 1");
  end

  // Vacated bit is either zero or the bit falling off the opposite end.
  if (SHIFT_DIR == SHIFT_LEFT && FILL_MODE == FILL_ZERO) begin : g_left_zero
    assign shift_val = {q_q[WIDTH-2:0], 1'b0};
  end else if (SHIFT_DIR == SHIFT_LEFT) begin : g_left_rot
    assign shift_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  end else if (FILL_MODE == FILL_ZERO) begin : g_right_zero
    assign shift_val = {1'b0, q_q[WIDTH-1:1]};
  end else begin : g_right_rot
    assign shift_val = {q_q[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    q_d = shift_val;
    if (rst) begin
      q_d = '0;
    end else if (load) begin
      q_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign pout = q_q;

endmodule

// File: tb/tb_pld_shift_reg.sv
// Drives all four shift/fill builds in lockstep and checks them against an arithmetic model.
module tb_pld_shift_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] p0, p1, p2, p3;
  logic [7:0] m [4];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pld_shift_reg #(.WIDTH(8), .SHIFT_DIR(0), .FILL_MODE(0)) u_lz (.clk(clk), .rst(rst), .load(load), .din(din), .pout(p0));
  pld_shift_reg #(.WIDTH(8), .SHIFT_DIR(0), .FILL_MODE(1)) u_lr (.clk(clk), .rst(rst), .load(load), .din(din), .pout(p1));
  pld_shift_reg #(.WIDTH(8), .SHIFT_DIR(1), .FILL_MODE(0)) u_rz (.clk(clk), .rst(rst), .load(load), .din(din), .pout(p2));
  pld_shift_reg #(.WIDTH(8), .SHIFT_DIR(1), .FILL_MODE(1)) u_rr (.clk(clk), .rst(rst), .load(load), .din(din), .pout(p3));

  function automatic logic [7:0] get_out(input int idx);
    case (idx)
      0: return p0;
      1: return p1;
      2: return p2;
      default: return p3;
    endcase
  endfunction

  // Reference shift from plain integer arithmetic: idx bit1 = right, bit0 = rotate.
  function automatic logic [7:0] ref_shift(input logic [7:0] v, input int idx);
    int u;
    u = int'(v);
    case (idx)
      0: return 8'((u * 2) % 256);
      1: return 8'(((u * 2) % 256) + (u / 128));
      2: return 8'(u / 2);
      default: return 8'((u / 2) + (u % 2) * 128);
    endcase
  endfunction

  task automatic check(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] obs;
    obs = get_out(idx);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d observed=%h expected=%h", tag, idx, obs, exp);
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    load = l;
    din = d;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (r) m[i] = 8'h00;
      else if (l) m[i] = d;
      else m[i] = ref_shift(m[i], i);
    end
    #1;
    for (int i = 0; i < 4; i++) check("model", i, m[i]);
  endtask

  initial begin
    logic [7:0] exp;
    logic [7:0] rd;

    // Reset dominates load with din all ones.
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    check("rst_over_load", 0, 8'h00);
    step(1'b0, 1'b0, 8'hFF);
    check("rst_release", 0, 8'h00);

    // Walk a single one out of the MSB, then stay at zero.
    step(1'b0, 1'b1, 8'h01);
    check("load01", 0, 8'h01);
    exp = 8'h01;
    for (int k = 0; k < 8; k++) begin
      exp = exp << 1;
      step(1'b0, 1'b0, 8'h00);
      check("walk", 0, exp);
    end
    step(1'b0, 1'b0, 8'h00);
    check("stay_zero", 0, 8'h00);

    // Held load recaptures each edge.
    step(1'b0, 1'b1, 8'h01);
    check("held1", 0, 8'h01);
    step(1'b0, 1'b1, 8'h09);
    check("held2", 0, 8'h09);
    step(1'b0, 1'b0, 8'h00); check("held_sh1", 0, 8'h12);
    step(1'b0, 1'b0, 8'h00); check("held_sh2", 0, 8'h24);
    step(1'b0, 1'b0, 8'h00); check("held_sh3", 0, 8'h48);
    step(1'b0, 1'b0, 8'h00); check("held_sh4", 0, 8'h90);
    step(1'b0, 1'b0, 8'h00); check("held_sh5", 0, 8'h20);

    // MSB drop-off then mid-shift reset.
    step(1'b0, 1'b1, 8'h41);
    step(1'b0, 1'b0, 8'h00); check("drop1", 0, 8'h82);
    step(1'b0, 1'b0, 8'h00); check("drop2", 0, 8'h04);
    step(1'b1, 1'b0, 8'h00); check("mid_rst", 0, 8'h00);

    // Rotate-left period.
    step(1'b0, 1'b1, 8'h81);
    step(1'b0, 1'b0, 8'h00); check("rotl1", 1, 8'h03);
    step(1'b0, 1'b0, 8'h00); check("rotl2", 1, 8'h06);
    step(1'b0, 1'b0, 8'h00); check("rotl3", 1, 8'h0C);
    for (int k = 3; k < 8; k++) step(1'b0, 1'b0, 8'h00);
    check("rotl_period", 1, 8'h81);

    // Right zero-fill.
    step(1'b0, 1'b1, 8'h90);
    step(1'b0, 1'b0, 8'h00); check("rz1", 2, 8'h48);
    step(1'b0, 1'b0, 8'h00); check("rz2", 2, 8'h24);
    step(1'b0, 1'b0, 8'h00); check("rz3", 2, 8'h12);
    step(1'b0, 1'b0, 8'h00); check("rz4", 2, 8'h09);
    step(1'b0, 1'b0, 8'h00); check("rz5", 2, 8'h04);

    // Right rotate wraps LSB into MSB.
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b0, 8'h00); check("rr1", 3, 8'h80);

    // din ignored while not loading, including X.
    step(1'b0, 1'b1, 8'hA5);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) step(1'b0, 1'b0, 8'hxx);
      else step(1'b0, 1'b0, 8'($urandom));
    end
    step(1'b1, 1'b0, 8'hxx);
    check("rst_din_x", 0, 8'h00);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 15) == 0) step(1'b1, 1'($urandom_range(0, 1)), rd);
      else if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, rd);
      else if ($urandom_range(0, 1) == 0) step(1'b0, 1'b0, 8'hxx);
      else step(1'b0, 1'b0, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pld_shift_reg.md
# pld_shift_reg

Parallel-load shift register: on each rising clock edge it either captures an 8-bit parallel word or shifts its contents by one bit position. The register contents drive the parallel output directly. It is a leaf datapath block used wherever a byte must be loaded and then walked out bit by bit, for example in serializers, pattern generators and LED chasers.

## Interface
Parameters:
- WIDTH, 8: register and data width in bits. The default build is 8.
- SHIFT_DIR, 0: shift direction. 0 = left (toward MSB), 1 = right (toward LSB).
- FILL_MODE, 0: source of the vacated bit. 0 = zero fill, 1 = rotate (the bit shifted out re-enters at the other end).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset. Synchronous and active-high; clears the register.
- load  input  1  parallel-load enable, sampled at the rising edge.
- din  input  WIDTH  parallel load data.
- pout  output  WIDTH  current register contents.

Port order is fixed as clk, rst, load, din, pout so that positional instantiation works.

## Operation
- A single WIDTH-bit register `q` drives pout directly, with no output logic.
- Priority at each rising edge of clk:
  1. rst = 1: q <= 0. This overrides load.
  2. load = 1: q <= din.
  3. Otherwise, shift:
     - Left, zero fill: q <= {q[WIDTH-2:0], 1'b0}.
     - Left, rotate: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
     - Right, zero fill: q <= {1'b0, q[WIDTH-1:1]}.
     - Right, rotate: q <= {q[0], q[WIDTH-1:1]}.
- load is level-sensitive. While load is held high, q re-captures din on every edge, and no shift occurs during those cycles.
- din is ignored whenever load = 0 or rst = 1. An X on din has no effect in those cycles.
- In zero-fill mode the register reaches all-zeros after WIDTH consecutive shift cycles and then stays at zero.
- In rotate mode the register contents are periodic with period WIDTH.
- There is no handshake, no busy flag and no serial output port. A serial bit can be taken from pout[WIDTH-1] (left) or pout[0] (right).

## Timing
- Reset value: pout = 0, visible after the first rising edge with rst = 1.
- Before the first reset, pout is undefined (X in simulation).
- Load latency: pout equals din one clock edge after load is sampled high.
- Shift latency: one bit position per clock edge while load = 0 and rst = 0.
- Simultaneous rst and load: reset wins, pout = 0.
- Reset asserted mid-sequence: the register clears on that edge. Shifting or loading resumes on the first edge after rst deasserts.
- No combinational path from any input to pout.

## Structure
- Shared package `pld_shift_pkg`:
  - localparams SHIFT_LEFT = 0 and SHIFT_RIGHT = 1.
  - localparams FILL_ZERO = 0 and FILL_ROTATE = 1.
- Build a single module with no sub-module.
  - The next-state value is one combinational mux (reset / load / shift variant) feeding one always block.
  - Use generate-if on SHIFT_DIR and FILL_MODE to select the shift expression.
- Add parameter legality checks:
  - WIDTH must be at least 2.
  - SHIFT_DIR and FILL_MODE must each be 0 or 1.
  - Report a violation with an elaboration-time error.

## Test plan
All scenarios use defaults (WIDTH = 8, left, zero fill) unless stated otherwise.
- Reset: rst = 1 with load = 1 and din = 8'hFF for 2 edges -> pout = 8'h00. Release rst with load = 0 -> pout stays 8'h00.
- Load then shift: pulse load for 1 edge with din = 8'h01 -> pout = 01, then 02, 04, 08, 10, 20, 40, 80, 00, and stays 00.
- Held load: load high for 2 edges with din changing 8'h01 -> 8'h09 -> pout = 01 then 09. Drop load -> pout = 12, 24, 48, 90, 20.
- MSB drop-off and reset mid-shift: load 8'h41 -> pout = 82, then 04. Assert rst on the next edge -> pout = 00.
- Rotate-left build: load 8'h81 -> pout = 03, 06, 0C. After 8 shifts in total from the load, pout = 81.
- Right, zero-fill build: load 8'h90 -> pout = 48, 24, 12, 09, 04.
- Right, rotate build: load 8'h01 -> pout = 80.
- Ignored din: with load = 0, drive din to X/random values -> shift sequence unaffected.
